encrypt_sequencer: RTL

Controller that sequences the LWE encryption accumulator. On `start` it walks the public key row by row, from row 0 to row DIMENSION. For each row it streams the elements of every selected public-key sample into the accumulator, injects the scaled message on the last row, and reads back each ciphertext word. It then emits the words on a valid/ready stream and finally clears the accumulator. It sits between the public-key memory, the accumulator datapath and the ciphertext output FIFO.

---
 rtl/encrypt_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/encrypt_sequencer.sv
// Sequences the LWE encryption accumulator: streams selected public-key samples row by row,
// injects the scaled message on the body row, reads back each word and emits it as ciphertext.
module encrypt_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int DIMENSION        = 10,
    parameter int DIM_WIDTH        = 4,
    parameter int BIG_N            = 30,
    parameter int N_WIDTH          = 5,
    parameter int RD_LAT           = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BIG_N-1:0]            sel,
    input  logic [PLAINTEXT_WIDTH-1:0]  msg,
    output logic                        busy,
    output logic                        pk_rd,
    output logic [N_WIDTH-1:0]          pk_sample,
    output logic [DIM_WIDTH-1:0]        pk_row,
    input  logic [CIPHERTEXT_WIDTH-1:0] pk_data,
    output logic                        dp_en,
    output logic [DIM_WIDTH-1:0]        dp_row,
    output logic [CIPHERTEXT_WIDTH-1:0] dp_op1,
    output logic [CIPHERTEXT_WIDTH-1:0] dp_op2,
    output logic                        dp_done,
    input  logic [CIPHERTEXT_WIDTH-1:0] dp_result,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic                        ct_last,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [2:0]                  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        FLUSH = 3'd2,
        READ  = 3'd3,
        OUT   = 3'd4,
        CLEAR = 3'd5
    } state_t;

    localparam int RC_W = $clog2(RD_LAT) + 1;

    state_t                        state, state_nx;
    logic [BIG_N-1:0]              sel_q;
    logic [BIG_N-1:0]              pend;
    logic [BIG_N-1:0]              pend_low;
    logic [N_WIDTH-1:0]            low_idx;
    logic [PLAINTEXT_WIDTH-1:0]    msg_q;
    logic [DIM_WIDTH-1:0]          row;
    logic [RC_W-1:0]               rd_cnt;
    logic                          inflight;
    logic [CIPHERTEXT_WIDTH-1:0]   ct_q;
    logic [CIPHERTEXT_WIDTH-1:0]   msg_term;
    logic                          last_row;
    logic                          rd_last;

    // pend holds the samples of the current row not yet read; the lowest set bit is next.
    always_comb begin
        pend_low = pend & (~pend + BIG_N'(1));
        low_idx  = '0;
        for (int i = BIG_N - 1; i >= 0; i--) begin
            if (pend[i]) low_idx = N_WIDTH'(i);
        end
    end

    assign last_row  = (row == DIM_WIDTH'(DIMENSION));
    assign rd_last   = (rd_cnt == RC_W'(RD_LAT - 1));
    assign msg_term  = CIPHERTEXT_WIDTH'(msg_q) << (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH);
    assign busy      = (state != IDLE);
    assign pk_row    = row;
    assign dp_row    = row;
    assign ct_data   = ct_q;
    assign state_dbg = state;

    // Ciphertext stream: a word transfers on a cycle where ct_valid and ct_ready are both high;
    // while ct_valid is high and ct_ready low, ct_data and ct_last hold and no reads are issued.
    always_comb begin
        state_nx  = state;
        pk_rd     = 1'b0;
        pk_sample = '0;
        dp_en     = inflight;
        dp_op1    = inflight ? pk_data : '0;
        dp_op2    = '0;
        dp_done   = 1'b0;
        ct_valid  = 1'b0;
        ct_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (sel == '0) ? FLUSH : ACC;
            end
            ACC: begin
                pk_rd     = 1'b1;
                pk_sample = low_idx;
                if ((pend & ~pend_low) == '0) state_nx = FLUSH;
            end
            FLUSH: begin
                // The body row's message beat rides alongside any in-flight key element.
                if (last_row) begin
                    dp_en  = 1'b1;
                    dp_op2 = msg_term;
                end
                state_nx = READ;
            end
            READ: begin
                if (rd_last) state_nx = OUT;
            end
            OUT: begin
                ct_valid = 1'b1;
                ct_last  = last_row;
                if (ct_ready) begin
                    if (last_row)           state_nx = CLEAR;
                    else if (sel_q == '0)   state_nx = FLUSH;
                    else                    state_nx = ACC;
                end
            end
            CLEAR: begin
                dp_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            msg_q    <= '0;
            pend     <= '0;
            row      <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            ct_q     <= '0;
        end else begin
            state    <= state_nx;
            inflight <= pk_rd;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q <= sel;
                        msg_q <= msg;
                        pend  <= sel;
                        row   <= '0;
                    end
                end
                ACC:   pend   <= pend & ~pend_low;
                FLUSH: rd_cnt <= '0;
                READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_last) ct_q <= dp_result;
                end
                OUT: begin
                    if (ct_ready && !last_row) begin
                        row  <= row + 1'b1;
                        pend <= sel_q;
                    end
                end
                CLEAR:   row <= '0;
                default: ;
            endcase
        end
    end

endmodule
